// File: rtl/mac_dot_sequencer_if.sv
// ---------------------------------------------------------------------------
// mac_dot_sequencer_if
//
// Operand / completion bus between the dot-product sequencer (master) and a
// 3-lane MAC unit (slave).
//
//   mac_en             master -> slave  single-cycle operation request
//   mac_weights_0..2   master -> slave  lane weights, lane 0 = earliest beat
//   mac_data_0..2      master -> slave  lane activations (unsigned)
//   mac_pre_sum        master -> slave  running sum the MAC adds onto
//   mac_done           slave -> master  completion level, high several cycles
//   mac_out            slave -> master  MAC result
// ---------------------------------------------------------------------------
interface mac_dot_sequencer_if #(
    parameter int W_BITWIDTH   = 8,
    parameter int IN_BITWIDTH  = W_BITWIDTH,
    parameter int OUT_BITWIDTH = 32
);
    logic                    mac_en;
    logic [W_BITWIDTH-1:0]   mac_weights_0;
    logic [W_BITWIDTH-1:0]   mac_weights_1;
    logic [W_BITWIDTH-1:0]   mac_weights_2;
    logic [IN_BITWIDTH-1:0]  mac_data_0;
    logic [IN_BITWIDTH-1:0]  mac_data_1;
    logic [IN_BITWIDTH-1:0]  mac_data_2;
    logic [OUT_BITWIDTH-1:0] mac_pre_sum;
    logic                    mac_done;
    logic [OUT_BITWIDTH-1:0] mac_out;

    modport master (
        output mac_en,
        output mac_weights_0, mac_weights_1, mac_weights_2,
        output mac_data_0, mac_data_1, mac_data_2,
        output mac_pre_sum,
        input  mac_done,
        input  mac_out
    );

    modport slave (
        input  mac_en,
        input  mac_weights_0, mac_weights_1, mac_weights_2,
        input  mac_data_0, mac_data_1, mac_data_2,
        input  mac_pre_sum,
        output mac_done,
        output mac_out
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// mac_dot_sequencer
//
// Initiator side of a 3-lane MAC. Accepts a streamed (weight, data) vector,
// packs beats into triples, issues one MAC operation per triple with the
// running sum as pre-sum, chains each MAC result into the next operation and
// finally presents the dot-product on a valid/ready result port.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   s_valid/s_ready      input beat handshake
//   s_weight, s_data     beat operands (data is an unsigned activation)
//   s_last               final beat of the vector
//   s_bias               initial pre-sum, sampled with the first beat only
//   mac                  MAC operand/completion bus (master side)
//   res_valid/res_ready  result handshake
//   res_data             final dot-product, holds after the handshake
//   busy                 high whenever the sequencer is not IDLE
//   err                  (MAC_SEQ_TIMEOUT_EN only) result was a watchdog abort
//
// Build option
//   MAC_SEQ_TIMEOUT_EN   adds a watchdog on the MAC waits; a timeout returns
//                        the partial sum with err=1 and drains the rest of
//                        the aborted vector.
// ---------------------------------------------------------------------------
module mac_dot_sequencer #(
    parameter int W_BITWIDTH      = 8,
    parameter int IN_BITWIDTH     = W_BITWIDTH,
    parameter int OUT_BITWIDTH    = 32,
    parameter int DONE_TO_OUT_DLY = 1,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                    clk,
    input  logic                    rstn,

    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [W_BITWIDTH-1:0]   s_weight,
    input  logic [IN_BITWIDTH-1:0]  s_data,
    input  logic                    s_last,
    input  logic [OUT_BITWIDTH-1:0] s_bias,

    mac_dot_sequencer_if.master     mac,

    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUT_BITWIDTH-1:0] res_data,
    output logic                    busy
`ifdef MAC_SEQ_TIMEOUT_EN
    ,
    output logic                    err
`endif
);

    if (DONE_TO_OUT_DLY < 1 || DONE_TO_OUT_DLY > 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("mac_dot_sequencer: DONE_TO_OUT_DLY must be 1..3 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT_DONE,
        SAMPLE,
        WAIT_LOW,
        RESULT
    } state_e;

    // Last value of the done-delay counter before SAMPLE is entered.
    localparam logic [1:0] DLY_LAST = 2'(DONE_TO_OUT_DLY - 1);

    state_e                  state_q, state_d;
    logic                    rdy_q;
    logic                    busy_q;
    logic                    res_valid_q;
    logic                    mac_en_q;
    logic [W_BITWIDTH-1:0]   w_q [3];
    logic [IN_BITWIDTH-1:0]  d_q [3];
    logic [1:0]              lane_q;       // next lane to fill in COLLECT
    logic                    last_q;       // current triple holds the last beat
    logic [OUT_BITWIDTH-1:0] acc_q;
    logic [OUT_BITWIDTH-1:0] res_q;
    logic                    done_prev_q;
    logic                    dly_run_q;    // mac_done rise seen, delay running
    logic [1:0]              dly_cnt_q;

    logic accept;
    logic done_rise;
    logic dly_hit;
    logic timeout;   // watchdog expired this cycle
    logic drop;      // draining beats of an aborted vector

    assign accept    = s_valid & rdy_q;
    assign done_rise = mac.mac_done & ~done_prev_q;
    // The rise cycle itself counts as the first delay cycle.
    assign dly_hit   = (done_rise | dly_run_q) && (dly_cnt_q == DLY_LAST);

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            drop_q;
    logic            err_q;

    assign timeout = ((state_q == WAIT_DONE) || (state_q == WAIT_LOW)) && (wd_q == WD_LAST);
    assign drop    = drop_q;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_q   <= '0;
            drop_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            // One budget covers both MAC waits of a single operation.
            if (state_q == ISSUE) begin
                wd_q <= '0;
            end else if ((state_q == WAIT_DONE) || (state_q == WAIT_LOW)) begin
                wd_q <= wd_q + 1'b1;
            end

            if (timeout) begin
                err_q <= 1'b1;
            end else if ((state_q == RESULT) && res_ready) begin
                err_q <= 1'b0;
            end

            // Only beats still to come need draining.
            if (timeout && !last_q) begin
                drop_q <= 1'b1;
            end else if ((state_q == COLLECT) && accept && s_last) begin
                drop_q <= 1'b0;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign drop    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = s_last ? ISSUE : COLLECT;
                end
            end
            COLLECT: begin
                if (drop) begin
                    if (accept && s_last) begin
                        state_d = IDLE;
                    end
                end else if (accept && (s_last || (lane_q == 2'd2))) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A MAC still showing done from an earlier op must clear first.
                if (!mac.mac_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (timeout) begin
                    state_d = RESULT;
                end else if (dly_hit) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (timeout) begin
                    state_d = RESULT;
                end else if (!mac.mac_done) begin
                    state_d = last_q ? RESULT : COLLECT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = drop ? COLLECT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the lane array is a handful of flops that drive outputs directly, so it is reset like any other register.
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            mac_en_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                w_q[i] <= '0;
                d_q[i] <= '0;
            end
            lane_q      <= 2'd0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            res_q       <= '0;
            done_prev_q <= 1'b0;
            dly_run_q   <= 1'b0;
            dly_cnt_q   <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments throughout; every right-hand side reads the pre-edge value.
            state_q     <= state_d;
            // Handshake and status outputs are registered off the next state.
            rdy_q       <= (state_d == IDLE) || (state_d == COLLECT);
            busy_q      <= (state_d != IDLE);
            res_valid_q <= (state_d == RESULT);
            mac_en_q    <= (state_q == ISSUE) && (state_d == WAIT_DONE);
            done_prev_q <= mac.mac_done;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q  <= s_bias;
                        w_q[0] <= s_weight;
                        d_q[0] <= s_data;
                        w_q[1] <= '0;
                        d_q[1] <= '0;
                        w_q[2] <= '0;
                        d_q[2] <= '0;
                        lane_q <= 2'd1;
                        last_q <= s_last;
                    end
                end
                COLLECT: begin
                    if (accept && !drop) begin
                        if (lane_q == 2'd0) begin
                            // First beat of a new triple clears the lanes so
                            // a short final triple is zero-padded.
                            w_q[0] <= s_weight;
                            d_q[0] <= s_data;
                            w_q[1] <= '0;
                            d_q[1] <= '0;
                            w_q[2] <= '0;
                            d_q[2] <= '0;
                        end else begin
                            w_q[lane_q] <= s_weight;
                            d_q[lane_q] <= s_data;
                        end
                        lane_q <= lane_q + 2'd1;
                        last_q <= s_last;
                    end
                end
                ISSUE: begin
                    dly_run_q <= 1'b0;
                    dly_cnt_q <= 2'd0;
                end
                WAIT_DONE: begin
                    if ((done_rise || dly_run_q) && !dly_hit) begin
                        dly_run_q <= 1'b1;
                        dly_cnt_q <= dly_cnt_q + 2'd1;
                    end
                end
                SAMPLE: begin
                    acc_q <= mac.mac_out;
                end
                WAIT_LOW: begin
                    if (state_d == COLLECT) begin
                        lane_q <= 2'd0;
                    end
                end
                default: begin
                end
            endcase

            // Capture on entry so res_data holds after the handshake.
            if ((state_d == RESULT) && (state_q != RESULT)) begin
                res_q <= acc_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_ready           = rdy_q;
    assign busy              = busy_q;
    assign res_valid         = res_valid_q;
    assign res_data          = res_q;

    assign mac.mac_en        = mac_en_q;
    assign mac.mac_weights_0 = w_q[0];
    assign mac.mac_weights_1 = w_q[1];
    assign mac.mac_weights_2 = w_q[2];
    assign mac.mac_data_0    = d_q[0];
    assign mac.mac_data_1    = d_q[1];
    assign mac.mac_data_2    = d_q[2];
    // The accumulator only changes in IDLE and SAMPLE, so the pre-sum is
    // stable from mac_en until the result is taken.
    assign mac.mac_pre_sum   = acc_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_sequencer
//
// Directed bench for mac_dot_sequencer with a behavioural 3-lane MAC model.
// Define MAC_SEQ_TIMEOUT_EN on both RTL and bench to include the watchdog test.
// ---------------------------------------------------------------------------
module tb_mac_dot_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_weight = '0;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic [31:0] s_bias = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        busy;
`ifdef MAC_SEQ_TIMEOUT_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_dot_sequencer_if #(.W_BITWIDTH(8), .IN_BITWIDTH(8), .OUT_BITWIDTH(32)) mac_bus ();

    mac_dot_sequencer #(
        .W_BITWIDTH     (8),
        .IN_BITWIDTH    (8),
        .OUT_BITWIDTH   (32),
        .DONE_TO_OUT_DLY(1),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_weight (s_weight),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_bias   (s_bias),
        .mac      (mac_bus),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .busy     (busy)
`ifdef MAC_SEQ_TIMEOUT_EN
        ,
        .err      (err)
`endif
    );

    // ------------------------------------------------------------------
    // MAC model: result = pre_sum + sum(w*d), done rises 3 cycles after
    // mac_en and stays high 4 cycles. Manual mode lets a test own mac_done.
    // ------------------------------------------------------------------
    bit          mac_auto = 1'b1;
    logic        man_done = 1'b0;
    logic        auto_done = 1'b0;
    logic [31:0] auto_out = '0;
    logic [31:0] mac_res = '0;
    int          mac_lat = 0;
    int          mac_hold = 0;
    int          en_pulses = 0;
    logic [7:0]  cap_w0, cap_w1, cap_w2, cap_d0, cap_d1, cap_d2;
    logic [31:0] cap_pre;

    assign mac_bus.mac_done = mac_auto ? auto_done : man_done;
    assign mac_bus.mac_out  = auto_out;

    always @(negedge clk) begin
        if (mac_bus.mac_en === 1'b1) begin
            en_pulses++;
            cap_w0  = mac_bus.mac_weights_0;
            cap_w1  = mac_bus.mac_weights_1;
            cap_w2  = mac_bus.mac_weights_2;
            cap_d0  = mac_bus.mac_data_0;
            cap_d1  = mac_bus.mac_data_1;
            cap_d2  = mac_bus.mac_data_2;
            cap_pre = mac_bus.mac_pre_sum;
        end
        if (!mac_auto) begin
            mac_lat   = 0;
            mac_hold  = 0;
            auto_done = 1'b0;
        end else if (mac_bus.mac_en === 1'b1) begin
            mac_res = cap_pre + 32'(cap_w0) * 32'(cap_d0)
                              + 32'(cap_w1) * 32'(cap_d1)
                              + 32'(cap_w2) * 32'(cap_d2);
            mac_lat = 3;
        end else if (mac_lat > 0) begin
            mac_lat--;
            if (mac_lat == 0) begin
                auto_done = 1'b1;
                auto_out  = mac_res;
                mac_hold  = 4;
            end
        end else if (mac_hold > 0) begin
            mac_hold--;
            if (mac_hold == 0) auto_done = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end on a falling edge)
    // ------------------------------------------------------------------
    task automatic send_beat(input logic [7:0] w, input logic [7:0] d,
                             input logic last, input logic [31:0] bias);
        int t = 0;
        s_valid  = 1'b1;
        s_weight = w;
        s_data   = d;
        s_last   = last;
        s_bias   = bias;
        while (s_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_beat: s_ready=%b never reached required 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_vector(input logic [47:0] wv, input logic [47:0] dv,
                               input int n, input logic [31:0] bias);
        for (int i = 0; i < n; i++) begin
            send_beat(wv[i*8 +: 8], dv[i*8 +: 8], (i == n - 1), bias);
        end
    endtask

    task automatic wait_res_valid(input string name);
        int t = 0;
        while (res_valid !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s wait: res_valid=%b, required 1 within 500 cycles", name, res_valid);
        end
    endtask

    task automatic finish_result(input string name, input logic [31:0] exp);
        wait_res_valid(name);
        n_checks++;
        if (res_data !== exp) begin
            n_fail++;
            $display("FAIL %s res_data: got %h, required %h", name, res_data, exp);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, busy, s_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s post-handshake {res_valid,busy,s_ready}: got %b, required 001",
                     name, {res_valid, busy, s_ready});
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({s_ready, mac_bus.mac_en, res_valid, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset flags {s_ready,mac_en,res_valid,busy}: got %b, required 0000",
                     {s_ready, mac_bus.mac_en, res_valid, busy});
        end
        n_checks++;
        if ({res_data, mac_bus.mac_pre_sum, mac_bus.mac_weights_0, mac_bus.mac_data_2} !== '0) begin
            n_fail++;
            $display("FAIL reset data res_data=%h pre_sum=%h w0=%h d2=%h, required all 0",
                     res_data, mac_bus.mac_pre_sum, mac_bus.mac_weights_0, mac_bus.mac_data_2);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({s_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle after reset {s_ready,busy}: got %b, required 10", {s_ready, busy});
        end
    endtask

    task automatic test_basic;
        int e0 = en_pulses;
        send_vector({8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1},
                    {8'd0, 8'd0, 8'd0, 8'd6, 8'd5, 8'd4}, 3, 32'd10);
        wait_res_valid("basic");
        n_checks++;
        if ({cap_w0, cap_w1, cap_w2, cap_d0, cap_d1, cap_d2} !== {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}) begin
            n_fail++;
            $display("FAIL basic operands: got w=%0d,%0d,%0d d=%0d,%0d,%0d, required w=1,2,3 d=4,5,6",
                     cap_w0, cap_w1, cap_w2, cap_d0, cap_d1, cap_d2);
        end
        n_checks++;
        if (cap_pre !== 32'd10) begin
            n_fail++;
            $display("FAIL basic pre_sum: got %0d, required 10", cap_pre);
        end
        n_checks++;
        if (en_pulses - e0 !== 1) begin
            n_fail++;
            $display("FAIL basic mac_en pulses: got %0d, required 1", en_pulses - e0);
        end
        finish_result("basic", 32'd42);
    endtask

    task automatic test_hold;
        send_vector({8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1},
                    {8'd0, 8'd0, 8'd0, 8'd6, 8'd5, 8'd4}, 3, 32'd10);
        wait_res_valid("hold");
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({res_valid, s_ready, res_data} !== {1'b1, 1'b0, 32'd42}) begin
                n_fail++;
                $display("FAIL hold cycle %0d: res_valid=%b s_ready=%b res_data=%0d, required 1 0 42",
                         i, res_valid, s_ready, res_data);
            end
            @(negedge clk);
        end
        finish_result("hold", 32'd42);
        n_checks++;
        if (res_data !== 32'd42) begin
            n_fail++;
            $display("FAIL hold res_data after handshake: got %0d, required 42", res_data);
        end
    endtask

    task automatic test_two_groups;
        int e0 = en_pulses;
        send_vector({8'd0, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                    {8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 5, 32'd0);
        wait_res_valid("two_groups");
        n_checks++;
        if (en_pulses - e0 !== 2) begin
            n_fail++;
            $display("FAIL two_groups mac_en pulses: got %0d, required 2", en_pulses - e0);
        end
        n_checks++;
        if ({cap_w0, cap_w1, cap_w2, cap_d0, cap_d1, cap_d2} !== {8'd4, 8'd5, 8'd0, 8'd1, 8'd1, 8'd0}) begin
            n_fail++;
            $display("FAIL two_groups second operands: got w=%0d,%0d,%0d d=%0d,%0d,%0d, required w=4,5,0 d=1,1,0",
                     cap_w0, cap_w1, cap_w2, cap_d0, cap_d1, cap_d2);
        end
        n_checks++;
        if (cap_pre !== 32'd6) begin
            n_fail++;
            $display("FAIL two_groups second pre_sum: got %0d, required 6", cap_pre);
        end
        finish_result("two_groups", 32'd15);
    endtask

    task automatic test_wrap;
        int e0 = en_pulses;
        send_beat(8'hFF, 8'd2, 1'b1, 32'hFFFF_FFFF);
        wait_res_valid("wrap");
        n_checks++;
        if ({cap_w0, cap_w1, cap_w2, cap_d0, cap_d1, cap_d2} !== {8'hFF, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL wrap padding: got w=%h,%h,%h d=%h,%h,%h, required w=ff,00,00 d=02,00,00",
                     cap_w0, cap_w1, cap_w2, cap_d0, cap_d1, cap_d2);
        end
        n_checks++;
        if (en_pulses - e0 !== 1) begin
            n_fail++;
            $display("FAIL wrap mac_en pulses: got %0d, required 1", en_pulses - e0);
        end
        finish_result("wrap", 32'h0000_01FD);
    endtask

    task automatic test_reset_mid;
        int e0;
        int e1;
        int t = 0;
        mac_auto = 1'b0;
        man_done = 1'b0;
        e0 = en_pulses;
        send_vector({8'd0, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2},
                    {8'd0, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2}, 3, 32'd7);
        while (en_pulses == e0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (busy !== 1'b1 || t >= 100) begin
            n_fail++;
            $display("FAIL reset_mid reach WAIT_DONE: busy=%b waited=%0d, required busy 1", busy, t);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, mac_bus.mac_en, res_valid, busy, res_data, mac_bus.mac_pre_sum, mac_bus.mac_weights_0} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: s_ready=%b mac_en=%b res_valid=%b busy=%b res_data=%h pre_sum=%h w0=%h, required all 0",
                     s_ready, mac_bus.mac_en, res_valid, busy, res_data, mac_bus.mac_pre_sum, mac_bus.mac_weights_0);
        end
        // The abandoned op now completes: done is high while the next vector arrives.
        man_done = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        e1 = en_pulses;
        send_vector({8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1},
                    {8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1}, 3, 32'd0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({mac_bus.mac_en, busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL reset_mid issue blocked cycle %0d {mac_en,busy}: got %b, required 01",
                         i, {mac_bus.mac_en, busy});
            end
            @(negedge clk);
        end
        n_checks++;
        if (en_pulses !== e1) begin
            n_fail++;
            $display("FAIL reset_mid spurious mac_en: got %0d pulses, required 0", en_pulses - e1);
        end
        man_done = 1'b0;
        mac_auto = 1'b1;
        finish_result("reset_mid", 32'd3);
        n_checks++;
        if (en_pulses - e1 !== 1) begin
            n_fail++;
            $display("FAIL reset_mid mac_en pulses: got %0d, required 1", en_pulses - e1);
        end
    endtask

`ifdef MAC_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int t = 0;
        int cyc = 0;
        mac_auto = 1'b0;
        man_done = 1'b0;
        send_beat(8'd3, 8'd3, 1'b1, 32'h0000_1234);
        while (mac_bus.mac_en !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        while (res_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 64) begin
            n_fail++;
            $display("FAIL timeout latency: got %0d cycles, required 64", cyc);
        end
        n_checks++;
        if ({err, res_data} !== {1'b1, 32'h0000_1234}) begin
            n_fail++;
            $display("FAIL timeout result: err=%b res_data=%h, required err=1 res_data=00001234", err, res_data);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_checks++;
        if ({err, res_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout post-handshake {err,res_valid,busy}: got %b, required 000",
                     {err, res_valid, busy});
        end
        mac_auto = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_two_groups();
        test_wrap();
        test_reset_mid();
`ifdef MAC_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
